// File: rtl/mirror_display.sv
// mirror_display: debounced 2-bit source select mirroring one of four sensor bytes to Display.
// Optional low-fuel comparator is enabled by defining MIRROR_DISPLAY_LOW_FUEL_EN.
module mirror_display #(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter logic [7:0] LOW_FUEL_THRESH = 8'd16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] Temperature,
    input  logic [7:0] Average_mpg,
    input  logic [7:0] Instantaneous_mpg,
    input  logic [7:0] Miles_remaining,
    input  logic [1:0] SS,
    output logic [7:0] Display,
    output logic       display_update,
    output logic       low_fuel
);
    localparam logic [7:0] DB = 8'(DEBOUNCE_CYCLES);

    logic [1:0] r_sync1, r_sync2, r_active, r_cand, r_disp_sel;
    logic [7:0] r_cnt;
    logic       w_restart;
    logic [7:0] w_cnt_next;
    logic [7:0] w_src;

    always_comb begin
        w_restart  = (r_cnt == 8'd0) || (r_sync2 != r_cand);
        w_cnt_next = w_restart ? 8'd1 : r_cnt + 8'd1;
        w_src      = (r_active == 2'b00) ? Temperature :
                     (r_active == 2'b01) ? Average_mpg :
                     (r_active == 2'b10) ? Instantaneous_mpg : Miles_remaining;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= SS;
            r_sync2 <= r_sync1;
        end
    end

    // Candidate is committed on the edge where its hold count reaches DB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 2'b00;
            r_cand   <= 2'b00;
            r_cnt    <= 8'd0;
        end else if (r_sync2 == r_active) begin
            r_cnt <= 8'd0;
        end else begin
            r_cand <= r_sync2;
            if (w_cnt_next == DB) begin
                r_active <= r_sync2;
                r_cnt    <= 8'd0;
            end else begin
                r_cnt <= w_cnt_next;
            end
        end
    end

    // r_disp_sel remembers which source produced the current Display value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Display        <= 8'h00;
            display_update <= 1'b0;
            r_disp_sel     <= 2'b00;
        end else begin
            Display        <= w_src;
            display_update <= (r_active != r_disp_sel);
            r_disp_sel     <= r_active;
        end
    end

`ifdef MIRROR_DISPLAY_LOW_FUEL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) low_fuel <= 1'b0;
        else        low_fuel <= (Miles_remaining < LOW_FUEL_THRESH);
    end
`else
    logic [7:0] w_unused_thresh;
    assign w_unused_thresh = LOW_FUEL_THRESH;
    assign low_fuel        = 1'b0;
`endif
endmodule

// File: tb/tb_mirror_display.sv
// tb_mirror_display: directed-vector bench for mirror_display (default DEBOUNCE_CYCLES=4).
module tb_mirror_display;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] Temperature = 8'h00;
    logic [7:0] Average_mpg = 8'h98;
    logic [7:0] Instantaneous_mpg = 8'h12;
    logic [7:0] Miles_remaining = 8'h78;
    logic [1:0] SS = 2'b00;
    logic [7:0] Display;
    logic       display_update;
    logic       low_fuel;
    int         n_chk = 0;
    int         n_pass = 0;

`ifdef MIRROR_DISPLAY_LOW_FUEL_EN
    localparam logic LF_EN = 1'b1;
`else
    localparam logic LF_EN = 1'b0;
`endif

    mirror_display dut (
        .clk(clk), .rst_n(rst_n),
        .Temperature(Temperature), .Average_mpg(Average_mpg),
        .Instantaneous_mpg(Instantaneous_mpg), .Miles_remaining(Miles_remaining),
        .SS(SS), .Display(Display), .display_update(display_update), .low_fuel(low_fuel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2;
        check("rst_display", Display, 8'h00);
        check("rst_update", {7'd0, display_update}, 8'h00);
        check("rst_low_fuel", {7'd0, low_fuel}, 8'h00);
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("idle_display", Display, 8'h00);
            check("idle_update", {7'd0, display_update}, 8'h00);
        end
        // clean change 00 -> 11
        SS = 2'b11;
        Miles_remaining = 8'h0F;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("sw11_pre_display", Display, 8'h00);
            check("sw11_pre_update", {7'd0, display_update}, 8'h00);
        end
        tick(1);
        check("sw11_e7_display", Display, 8'h0F);
        check("sw11_e7_update", {7'd0, display_update}, 8'h01);
        check("low_fuel_0f", {7'd0, low_fuel}, {7'd0, LF_EN});
        tick(1);
        check("sw11_e8_update", {7'd0, display_update}, 8'h00);
        check("sw11_e8_display", Display, 8'h0F);
        // back to 00, then glitch on SS=01
        SS = 2'b00;
        Temperature = 8'h5A;
        tick(6);
        check("sw00_e6_display", Display, 8'h0F);
        tick(1);
        check("sw00_e7_display", Display, 8'h5A);
        check("sw00_e7_update", {7'd0, display_update}, 8'h01);
        tick(1);
        SS = 2'b01;
        tick(2);
        SS = 2'b00;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_display", Display, 8'h5A);
            check("glitch_update", {7'd0, display_update}, 8'h00);
        end
        // select 10, then a sensor change follows in one edge
        SS = 2'b10;
        tick(7);
        check("sw10_display", Display, 8'h12);
        check("sw10_update", {7'd0, display_update}, 8'h01);
        tick(1);
        Instantaneous_mpg = 8'h34;
        tick(1);
        check("sensor_display", Display, 8'h34);
        check("sensor_update", {7'd0, display_update}, 8'h00);
        Miles_remaining = 8'h10;
        tick(1);
        check("low_fuel_10", {7'd0, low_fuel}, 8'h00);
        Miles_remaining = 8'h0F;
        tick(1);
        check("low_fuel_0f_again", {7'd0, low_fuel}, {7'd0, LF_EN});
        Miles_remaining = 8'hFF;
        tick(1);
        check("low_fuel_ff", {7'd0, low_fuel}, 8'h00);
        // return to 00, then reset mid-debounce of 00 -> 11
        SS = 2'b00;
        Miles_remaining = 8'h0F;
        tick(8);
        check("sw00b_display", Display, 8'h5A);
        SS = 2'b11;
        tick(4);
        check("mid_db_display", Display, 8'h5A);
        rst_n = 1'b0;
        #1;
        check("mid_rst_display", Display, 8'h00);
        check("mid_rst_update", {7'd0, display_update}, 8'h00);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("post_rst_e1_display", Display, 8'h5A);
        for (int i = 2; i <= 6; i++) begin
            tick(1);
            check("post_rst_pre_display", Display, 8'h5A);
            check("post_rst_pre_update", {7'd0, display_update}, 8'h00);
        end
        tick(1);
        check("post_rst_e7_display", Display, 8'h0F);
        check("post_rst_e7_update", {7'd0, display_update}, 8'h01);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mirror_display.md
MIRROR_DISPLAY -- requirements
Module: mirror_display

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, meaning: consecutive clock edges a synchronized selector value must be stable before it takes effect; legal range 1-255.
REQ-002 Parameter LOW_FUEL_THRESH, default 8'd16, meaning: Miles_remaining value below which the low-fuel flag asserts.
REQ-003 Port clk, input, 1 bit, meaning: single system clock, rising-edge active; the block SHALL use one clock and reset SHALL be asynchronous, active-low.
REQ-004 Port rst_n, input, 1 bit, meaning: asynchronous active-low reset.
REQ-005 Port Temperature, input, 8 bits, meaning: temperature sensor value, unsigned, synchronous to clk.
REQ-006 Port Average_mpg, input, 8 bits, meaning: average mpg sensor value, unsigned, synchronous to clk.
REQ-007 Port Instantaneous_mpg, input, 8 bits, meaning: instantaneous mpg sensor value, unsigned, synchronous to clk.
REQ-008 Port Miles_remaining, input, 8 bits, meaning: miles-remaining sensor value, unsigned, synchronous to clk.
REQ-009 Port SS, input, 2 bits, meaning: selector switches, asynchronous to clk.
REQ-010 Port Display, output, 8 bits, meaning: registered mirror display value.
REQ-011 Port display_update, output, 1 bit, meaning: one-cycle pulse when the displayed source changes.
REQ-012 Port low_fuel, output, 1 bit, meaning: registered low-fuel warning, present in both configurations.

Function
REQ-013 SS SHALL pass through a 2-flop synchronizer before any use; the second stage is the synced select.
REQ-014 Source mapping SHALL be: active select 00 -> Temperature, 01 -> Average_mpg, 10 -> Instantaneous_mpg, 11 -> Miles_remaining.
REQ-015 Debounce: when the synced select differs from the active select, a candidate value and counter SHALL track it; a change of synced value restarts the counter at 1 with the new candidate.
REQ-016 The active select SHALL update to the candidate on the edge at which the candidate has been held for DEBOUNCE_CYCLES consecutive edges; a synced value equal to the active select clears the counter.
REQ-017 Display SHALL register the input chosen by the active select every clock edge; latency from a sensor input change to Display is 1 edge.
REQ-018 With DEBOUNCE_CYCLES=4, a clean SS change SHALL appear on Display at the 7th rising edge after SS changes (2 sync + 4 debounce + 1 output).
REQ-019 display_update SHALL be high for exactly one cycle, coincident with the first Display value from the new source; it SHALL stay low if the select glitch never completes debounce.
REQ-020 Selector toggles shorter than DEBOUNCE_CYCLES edges after synchronization SHALL leave Display source and display_update unaffected.
REQ-021 Display SHALL pass input bits unmodified; no arithmetic or saturation is applied.

Reset
REQ-022 On rst_n low, asynchronously: synchronizer flops, active select, candidate = 2'b00; counter = 0; Display = 8'h00; display_update = 0; low_fuel = 0.
REQ-023 After rst_n deasserts, the block SHALL resume with Temperature displayed from the first rising edge; reset mid-debounce SHALL discard the pending candidate.

Configuration
REQ-024 Macro MIRROR_DISPLAY_LOW_FUEL_EN: when defined, low_fuel SHALL register (Miles_remaining < LOW_FUEL_THRESH) every edge, independent of SS.
REQ-025 Without MIRROR_DISPLAY_LOW_FUEL_EN, low_fuel SHALL be constant 0 and no comparator logic SHALL be present.

Verification
REQ-026 Reset with SS=00, Temperature=8'h00, Average_mpg=8'h98, Instantaneous_mpg=8'h12, Miles_remaining=8'h78 -> Display=8'h00, display_update=0 throughout.
REQ-027 After reset, set SS=11, Miles_remaining=8'h0F, hold -> Display=8'h0F at 7th edge, display_update single pulse that cycle.
REQ-028 Active select 00, pulse SS=01 for 2 edges then back to 00 -> Display stays Temperature value, display_update never asserts.
REQ-029 Active select 10, change Instantaneous_mpg 8'h12 -> 8'h34 -> Display=8'h34 one edge later, no display_update.
REQ-030 MIRROR_DISPLAY_LOW_FUEL_EN defined: Miles_remaining=8'h0F -> low_fuel=1 next edge; 8'h10 -> 0; macro undefined -> low_fuel=0 always.
REQ-031 Assert rst_n low mid-debounce of SS 00->11 -> Display=8'h00 immediately, select returns to 00 and Temperature is displayed after release even with SS held at 11 until debounce re-completes.
